// File: rtl/render_pkg.sv
// Shared constants and FSM encoding for the frame-synchronous matrix update sequencer.
package render_pkg;

    localparam int unsigned MTRX_W   = 336;
    localparam int unsigned ST_W     = 4;
    localparam logic [9:0]  V_ACTIVE = 10'd480;
    localparam int unsigned NORM_LAT = 4;
    localparam int unsigned FCNT_W   = 16;
    localparam int unsigned CNT_W    = $clog2(NORM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        SETTLE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/render_frame_sequencer_if.sv
// Host-side update handshake: the host offers a matrix/state pair, the sequencer acks its capture.
interface render_frame_sequencer_if;
    import render_pkg::*;

    logic              upd_req;
    logic [MTRX_W-1:0] mtrx_wr;
    logic [ST_W-1:0]   state_wr;
    logic              upd_ack;

    modport master (output upd_req, mtrx_wr, state_wr, input  upd_ack);
    modport slave  (input  upd_req, mtrx_wr, state_wr, output upd_ack);

endinterface

// File: rtl/vblank_edge_det.sv
// Flags the single cycle in which the line counter first reaches the blanking line.
module vblank_edge_det
    import render_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] v_cnt,
    output logic       vblank_edge
);

    logic [9:0] v_cnt_q;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v_cnt_q <= '0;
        else        v_cnt_q <= v_cnt;
    end

    assign vblank_edge = (v_cnt == V_ACTIVE) && (v_cnt_q != V_ACTIVE);

endmodule

// File: rtl/render_frame_sequencer.sv
// Buffers host matrix updates and commits them to the vertex datapath only at vblank entry,
// masking geom_valid while the datapath settles.
module render_frame_sequencer
    import render_pkg::*;
(
    input  logic                     CLK,
    input  logic                     rst_n,
    render_frame_sequencer_if.slave  host,
    input  logic [9:0]               v_cnt,
    output logic [MTRX_W-1:0]        mtrx_out,
    output logic [ST_W-1:0]          state_out,
    output logic                     geom_valid,
    output logic                     commit_pulse,
    output logic                     pending,
    output logic [FCNT_W-1:0]        frame_cnt,
    output logic [7:0]               overrun_cnt
);

    logic vblank_edge;

    vblank_edge_det u_vblank_edge_det (
        .clk         (CLK),
        .rst_n       (rst_n),
        .v_cnt       (v_cnt),
        .vblank_edge (vblank_edge)
    );

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MTRX_W-1:0] buf_mtrx_q, buf_mtrx_d;
    logic [ST_W-1:0]   buf_state_q, buf_state_d;
    logic [MTRX_W-1:0] mtrx_out_q, mtrx_out_d;
    logic [ST_W-1:0]   state_out_q, state_out_d;
    logic              geom_valid_q, geom_valid_d;
    logic              commit_pulse_q, commit_pulse_d;
    logic              pending_q, pending_d;
    logic              upd_ack_q, upd_ack_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]        overrun_cnt_q, overrun_cnt_d;

    logic capture;
    logic commit_now;

    // A held request is only re-sampled once the previous ack has been seen.
    assign capture    = host.upd_req && !upd_ack_q;
    assign commit_now = vblank_edge && pending_q;

    always_comb begin
        // NOTE: every _d starts from a default so no branch can leave it unassigned and infer a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        buf_mtrx_d     = buf_mtrx_q;
        buf_state_d    = buf_state_q;
        mtrx_out_d     = mtrx_out_q;
        state_out_d    = state_out_q;
        commit_pulse_d = 1'b0;
        pending_d      = pending_q;
        upd_ack_d      = capture;
        frame_cnt_d    = frame_cnt_q;
        overrun_cnt_d  = overrun_cnt_q;

        if (capture) begin
            buf_mtrx_d  = host.mtrx_wr;
            buf_state_d = host.state_wr;
        end

        // The commit drains the pre-edge buffer, so a same-cycle capture stays pending and is no overrun.
        if (commit_now) pending_d = 1'b0;
        if (capture)    pending_d = 1'b1;
        if (capture && pending_q && !commit_now && (overrun_cnt_q != 8'hFF))
            overrun_cnt_d = overrun_cnt_q + 8'd1;

        if (vblank_edge) frame_cnt_d = frame_cnt_q + FCNT_W'(1);

        unique case (state_q)
            IDLE:   ;
            COMMIT: begin
                state_d = SETTLE;
                cnt_d   = CNT_W'(NORM_LAT);
            end
            SETTLE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (commit_now) begin
            state_d        = COMMIT;
            mtrx_out_d     = buf_mtrx_q;
            state_out_d    = buf_state_q;
            commit_pulse_d = 1'b1;
        end

        geom_valid_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SETTLE;
            cnt_q          <= CNT_W'(NORM_LAT);
            mtrx_out_q     <= '0;
            state_out_q    <= '0;
            geom_valid_q   <= 1'b0;
            commit_pulse_q <= 1'b0;
            pending_q      <= 1'b0;
            upd_ack_q      <= 1'b0;
            frame_cnt_q    <= '0;
            overrun_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mtrx_out_q     <= mtrx_out_d;
            state_out_q    <= state_out_d;
            geom_valid_q   <= geom_valid_d;
            commit_pulse_q <= commit_pulse_d;
            pending_q      <= pending_d;
            upd_ack_q      <= upd_ack_d;
            frame_cnt_q    <= frame_cnt_d;
            overrun_cnt_q  <= overrun_cnt_d;
        end
    end

    // NOTE: the pending buffer is deliberately unreset; it is only read once pending_q marks it valid.
    always_ff @(posedge CLK) begin
        buf_mtrx_q  <= buf_mtrx_d;
        buf_state_q <= buf_state_d;
    end

    assign host.upd_ack = upd_ack_q;
    assign mtrx_out     = mtrx_out_q;
    assign state_out    = state_out_q;
    assign geom_valid   = geom_valid_q;
    assign commit_pulse = commit_pulse_q;
    assign pending      = pending_q;
    assign frame_cnt    = frame_cnt_q;
    assign overrun_cnt  = overrun_cnt_q;

endmodule

// File: tb/tb_render_frame_sequencer.sv
// Directed bench for render_frame_sequencer: handshake, commit timing, overrun, wrap and async reset.
module tb_render_frame_sequencer;
    import render_pkg::*;

    logic              CLK = 1'b0;
    logic              rst_n;
    logic [9:0]        v_cnt;
    logic [MTRX_W-1:0] mtrx_out;
    logic [ST_W-1:0]   state_out;
    logic              geom_valid;
    logic              commit_pulse;
    logic              pending;
    logic [FCNT_W-1:0] frame_cnt;
    logic [7:0]        overrun_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [MTRX_W-1:0] mtrx_a;
    logic [MTRX_W-1:0] mtrx_b;
    logic [MTRX_W-1:0] mtrx_c;

    render_frame_sequencer_if intf ();

    render_frame_sequencer dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .host         (intf),
        .v_cnt        (v_cnt),
        .mtrx_out     (mtrx_out),
        .state_out    (state_out),
        .geom_valid   (geom_valid),
        .commit_pulse (commit_pulse),
        .pending      (pending),
        .frame_cnt    (frame_cnt),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic vblank();
        v_cnt = 10'd479;
        step();
        v_cnt = 10'd480;
        step();
    endtask

    task automatic capture(input logic [MTRX_W-1:0] m, input logic [ST_W-1:0] s);
        intf.upd_req  = 1'b1;
        intf.mtrx_wr  = m;
        intf.state_wr = s;
        step();
        intf.upd_req  = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        v_cnt         = 10'd0;
        intf.upd_req  = 1'b0;
        intf.mtrx_wr  = '0;
        intf.state_wr = '0;
        #12;
        tests_run++;
        if ({geom_valid, commit_pulse, pending, intf.upd_ack} !== 4'b0000 || frame_cnt !== 16'd0 ||
            overrun_cnt !== 8'd0 || mtrx_out !== '0 || state_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_values: gv=%b cp=%b pend=%b ack=%b fc=%0d oc=%0d st=%0h, required all zero",
                     geom_valid, commit_pulse, pending, intf.upd_ack, frame_cnt, overrun_cnt, state_out);
        end
        rst_n = 1'b1;
        repeat (3) step();
        tests_run++;
        if (geom_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_settle_early: geom_valid=%b required 0", geom_valid);
        end
        step();
        tests_run++;
        if (geom_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_settle_done: geom_valid=%b required 1", geom_valid);
        end
        vblank();
        tests_run++;
        if (frame_cnt !== 16'd1 || commit_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_vblank: frame_cnt=%0d commit_pulse=%b required 1 and 0", frame_cnt, commit_pulse);
        end
    endtask

    task automatic test_commit();
        intf.upd_req  = 1'b1;
        intf.mtrx_wr  = mtrx_a;
        intf.state_wr = 4'h3;
        step();
        tests_run++;
        if (intf.upd_ack !== 1'b1 || pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL commit_ack: ack=%b pending=%b required 1 and 1", intf.upd_ack, pending);
        end
        intf.upd_req = 1'b0;
        step();
        tests_run++;
        if (intf.upd_ack !== 1'b0 || mtrx_out !== '0) begin
            tests_failed++;
            $display("FAIL commit_hold: ack=%b mtrx_out=%h required 0 and 0", intf.upd_ack, mtrx_out);
        end
        vblank();
        tests_run++;
        if (commit_pulse !== 1'b1 || state_out !== 4'h3 || mtrx_out !== mtrx_a ||
            geom_valid !== 1'b0 || pending !== 1'b0 || frame_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL commit_edge: cp=%b st=%0h gv=%b pend=%b fc=%0d required 1 3 0 0 2",
                     commit_pulse, state_out, geom_valid, pending, frame_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (geom_valid !== 1'b0 || commit_pulse !== 1'b0) begin
                tests_failed++;
                $display("FAIL commit_settle_%0d: gv=%b cp=%b required 0 and 0", i, geom_valid, commit_pulse);
            end
        end
        step();
        tests_run++;
        if (geom_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL commit_geom_valid: geom_valid=%b required 1", geom_valid);
        end
    endtask

    task automatic test_overrun();
        capture(mtrx_a, 4'h1);
        tests_run++;
        if (overrun_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL overrun_first: overrun_cnt=%0d required 0", overrun_cnt);
        end
        capture(mtrx_b, 4'h2);
        tests_run++;
        if (overrun_cnt !== 8'd1 || pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_second: overrun_cnt=%0d pending=%b required 1 and 1", overrun_cnt, pending);
        end
        vblank();
        tests_run++;
        if (mtrx_out !== mtrx_b || state_out !== 4'h2 || frame_cnt !== 16'd3) begin
            tests_failed++;
            $display("FAIL overrun_latest: mtrx_out=%h state_out=%0h frame_cnt=%0d required %h 2 3",
                     mtrx_out, state_out, frame_cnt, mtrx_b);
        end
    endtask

    task automatic test_simultaneous();
        capture(mtrx_c, 4'h5);
        v_cnt = 10'd479;
        step();
        v_cnt         = 10'd480;
        intf.upd_req  = 1'b1;
        intf.mtrx_wr  = mtrx_b;
        intf.state_wr = 4'h6;
        step();
        intf.upd_req = 1'b0;
        tests_run++;
        if (commit_pulse !== 1'b1 || mtrx_out !== mtrx_c || state_out !== 4'h5 ||
            pending !== 1'b1 || intf.upd_ack !== 1'b1 || overrun_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL simul_edge: cp=%b st=%0h pend=%b ack=%b oc=%0d required 1 5 1 1 1",
                     commit_pulse, state_out, pending, intf.upd_ack, overrun_cnt);
        end
        vblank();
        tests_run++;
        if (mtrx_out !== mtrx_b || state_out !== 4'h6 || pending !== 1'b0 || frame_cnt !== 16'd5) begin
            tests_failed++;
            $display("FAIL simul_next: st=%0h pend=%b fc=%0d required 6 0 5", state_out, pending, frame_cnt);
        end
    endtask

    task automatic test_async_reset();
        capture(mtrx_a, 4'h9);
        vblank();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({geom_valid, commit_pulse, pending, intf.upd_ack} !== 4'b0000 || frame_cnt !== 16'd0 ||
            overrun_cnt !== 8'd0 || mtrx_out !== '0 || state_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL async_reset: gv=%b cp=%b pend=%b ack=%b fc=%0d oc=%0d st=%0h, required all zero",
                     geom_valid, commit_pulse, pending, intf.upd_ack, frame_cnt, overrun_cnt, state_out);
        end
        v_cnt = 10'd0;
        #2;
        rst_n = 1'b1;
        repeat (4) step();
        tests_run++;
        if (geom_valid !== 1'b1 || pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_recover: gv=%b pend=%b required 1 and 0", geom_valid, pending);
        end
    endtask

    task automatic test_frame_wrap();
        for (int i = 0; i < 65535; i++) vblank();
        tests_run++;
        if (frame_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL frame_max: frame_cnt=%h required ffff", frame_cnt);
        end
        vblank();
        tests_run++;
        if (frame_cnt !== 16'h0000) begin
            tests_failed++;
            $display("FAIL frame_wrap: frame_cnt=%h required 0000", frame_cnt);
        end
    endtask

    task automatic test_overrun_saturate();
        intf.upd_req  = 1'b1;
        intf.mtrx_wr  = mtrx_c;
        intf.state_wr = 4'hA;
        step();
        tests_run++;
        if (intf.upd_ack !== 1'b1 || overrun_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL held_req_first: ack=%b oc=%0d required 1 and 0", intf.upd_ack, overrun_cnt);
        end
        step();
        tests_run++;
        if (intf.upd_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL held_req_gap: ack=%b required 0", intf.upd_ack);
        end
        step();
        tests_run++;
        if (intf.upd_ack !== 1'b1 || overrun_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL held_req_second: ack=%b oc=%0d required 1 and 1", intf.upd_ack, overrun_cnt);
        end
        repeat (508) step();
        tests_run++;
        if (overrun_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL overrun_reach_255: overrun_cnt=%0d required 255", overrun_cnt);
        end
        repeat (88) step();
        intf.upd_req = 1'b0;
        tests_run++;
        if (overrun_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL overrun_saturate: overrun_cnt=%0d required 255", overrun_cnt);
        end
    endtask

    initial begin
        mtrx_a = {16{21'h00001}};
        mtrx_b = {16{21'h0ABCD}};
        mtrx_c = {16{21'h1F00F}};
        test_reset();
        test_commit();
        test_overrun();
        test_simultaneous();
        test_async_reset();
        test_frame_wrap();
        test_overrun_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
